// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: posted store FIFO between exu and mems with load priority and RAW drain-through
module dmem_store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ex_req_i,
  input  logic                ex_we_i,
  input  logic [ADDR_W-1:0]   ex_addr_i,
  input  logic [DATA_W-1:0]   ex_wdata_i,
  input  logic [DATA_W/8-1:0] ex_wmask_i,
  output logic [DATA_W-1:0]   ex_rdata_o,
  output logic                hold_flag_o,
  input  logic                drain_req_i,
  output logic                empty_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wmask_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  input  logic                mem_hold_i
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] IDLE = 2'd0, DRAIN = 2'd1, FLUSH = 2'd2;
  logic [ADDR_W-1:0]   ent_addr [DEPTH];
  logic [DATA_W-1:0]   ent_data [DEPTH];
  logic [DATA_W/8-1:0] ent_mask [DEPTH];
  logic [AW:0] wp, rp, cnt, cnt_n;
  logic [1:0] state, state_n;
  logic [DEPTH-1:0] vld, match;
  logic ld, st, fl, hit, lg, dr, push, pop;
  for (genvar i = 0; i < DEPTH; i++) begin : g_e
    // entry i is live when its distance from the head is below the count
    assign vld[i]   = {1'b0, AW'(i) - rp[AW-1:0]} < cnt;
    assign match[i] = ent_addr[i][ADDR_W-1:2] == ex_addr_i[ADDR_W-1:2];
  end
  always_comb begin
    ld   = ex_req_i & ~ex_we_i;
    st   = ex_req_i & ex_we_i;
    fl   = state == FLUSH;
    hit  = |(vld & match);
    lg   = rst_n & ld & ~hit & ~fl;
    dr   = rst_n & (|cnt) & ~lg;
    push = rst_n & st & ~cnt[AW] & ~fl;
    pop  = dr & ~mem_hold_i;
    cnt_n = (push & ~pop) ? cnt + 1'b1 : (pop & ~push) ? cnt - 1'b1 : cnt;
    state_n = (cnt_n == '0) ? IDLE : (fl | (drain_req_i & (|cnt))) ? FLUSH : DRAIN;
    hold_flag_o = rst_n & ex_req_i & ~(push | (lg & ~mem_hold_i));
    empty_o     = ~rst_n | (cnt == '0);
    mem_req_o   = lg | dr;
    mem_we_o    = dr;
    mem_addr_o  = lg ? ex_addr_i : dr ? ent_addr[rp[AW-1:0]] : '0;
    mem_wdata_o = dr ? ent_data[rp[AW-1:0]] : '0;
    mem_wmask_o = dr ? ent_mask[rp[AW-1:0]] : '0;
    ex_rdata_o  = lg ? mem_rdata_i : '0;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      cnt   <= '0;
      state <= IDLE;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt   <= cnt_n;
      state <= state_n;
    end
  always_ff @(posedge clk)
    if (push) begin
      ent_addr[wp[AW-1:0]] <= ex_addr_i;
      ent_data[wp[AW-1:0]] <= ex_wdata_i;
      ent_mask[wp[AW-1:0]] <= ex_wmask_i;
    end
endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb_dmem_store_buffer: queue-based reference model checked every cycle plus directed literal checks
module tb_dmem_store_buffer;
  logic clk = 0, rst_n = 0;
  logic ex_req = 0, ex_we = 0, drain_req = 0, mem_hold = 0;
  logic [31:0] ex_addr = 0, ex_wdata = 0, ex_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0] ex_wmask = 0, mem_wmask;
  logic hold, empty, mem_req, mem_we;
  int checks = 0, errors = 0;
  typedef struct packed {logic [31:0] a; logic [31:0] d; logic [3:0] m;} ent_t;
  ent_t q[$];
  logic [31:0] wlog[$];
  logic fl = 0;
  always #5 clk = ~clk;
  assign mem_rdata = ex_addr ^ 32'h5A5A5A5A;
  dmem_store_buffer dut (
    .clk(clk), .rst_n(rst_n), .ex_req_i(ex_req), .ex_we_i(ex_we), .ex_addr_i(ex_addr),
    .ex_wdata_i(ex_wdata), .ex_wmask_i(ex_wmask), .ex_rdata_o(ex_rdata), .hold_flag_o(hold),
    .drain_req_i(drain_req), .empty_o(empty), .mem_req_o(mem_req), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_wmask_o(mem_wmask),
    .mem_rdata_i(mem_rdata), .mem_hold_i(mem_hold)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    logic hit, lg, dr, acc, e_hold, e_req, e_we, e_empty;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [3:0] e_mask;
    int n0;
    hit = 0; lg = 0; dr = 0; acc = 0;
    if (!rst_n) begin
      {e_hold, e_req, e_we, e_addr, e_wdata, e_mask, e_rdata} = '0;
      e_empty = 1;
    end else begin
      foreach (q[k]) if (q[k].a[31:2] == ex_addr[31:2]) hit = 1;
      lg = ex_req && !ex_we && !hit && !fl;
      dr = q.size() > 0 && !lg;
      acc = ex_req && ex_we && q.size() < 4 && !fl;
      e_hold  = ex_req && !(acc || (lg && !mem_hold));
      e_req   = lg || dr;
      e_we    = dr;
      e_addr  = lg ? ex_addr : dr ? q[0].a : 0;
      e_wdata = dr ? q[0].d : 0;
      e_mask  = dr ? q[0].m : 0;
      e_rdata = lg ? mem_rdata : 0;
      e_empty = q.size() == 0;
    end
    chk("m_hold", {31'b0, hold}, {31'b0, e_hold});
    chk("m_empty", {31'b0, empty}, {31'b0, e_empty});
    chk("m_req", {31'b0, mem_req}, {31'b0, e_req});
    chk("m_we", {31'b0, mem_we}, {31'b0, e_we});
    chk("m_addr", mem_addr, e_addr);
    chk("m_wdata", mem_wdata, e_wdata);
    chk("m_wmask", {28'b0, mem_wmask}, {28'b0, e_mask});
    chk("m_rdata", ex_rdata, e_rdata);
    if (mem_req && mem_we && !mem_hold && rst_n) wlog.push_back(mem_addr);
    if (!rst_n) begin
      q.delete();
      fl = 0;
    end else begin
      n0 = q.size();
      if (dr && !mem_hold) void'(q.pop_front());
      if (acc) q.push_back({ex_addr, ex_wdata, ex_wmask});
      fl = (fl || (drain_req && n0 > 0)) && q.size() > 0;
    end
  end
  task automatic go; @(posedge clk); #1; endtask
  task automatic st(input logic [31:0] a, input logic [31:0] d);
    ex_req = 1; ex_we = 1; ex_addr = a; ex_wdata = d; ex_wmask = 4'hF;
  endtask
  task automatic ld(input logic [31:0] a);
    ex_req = 1; ex_we = 0; ex_addr = a;
  endtask
  task automatic idle; ex_req = 0; ex_we = 0; endtask
  task automatic wait_empty(input string name);
    for (int n = 0; n < 50 && !empty; n++) go;
    @(negedge clk) chk(name, {31'b0, empty}, 32'd1);
    go;
  endtask
  initial begin
    go; go;
    rst_n = 1;
    @(negedge clk);
    chk("rst_empty", {31'b0, empty}, 32'd1);
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_hold", {31'b0, hold}, 32'd0);
    go;
    mem_hold = 1;
    for (int i = 0; i < 4; i++) begin
      st(i * 4, 32'h1000 + i);
      @(negedge clk) chk("fill_acc", {31'b0, hold}, 32'd0);
      go;
    end
    st(32'h10, 32'h1004);
    @(negedge clk) chk("full_hold", {31'b0, hold}, 32'd1);
    go;
    mem_hold = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (!hold) break;
      go;
    end
    chk("st10_acc", {31'b0, hold}, 32'd0);
    go; idle;
    wait_empty("fill_empty");
    chk("wlog_n", wlog.size(), 32'd5);
    for (int i = 0; i < 5 && i < wlog.size(); i++) chk("wlog_ord", wlog[i], i * 4);
    st(32'h100, 32'hDEADBEEF);
    go;
    ld(32'h104);
    @(negedge clk);
    chk("raw_miss_we", {31'b0, mem_we}, 32'd0);
    chk("raw_miss_addr", mem_addr, 32'h104);
    chk("raw_miss_rd", ex_rdata, 32'h5A5A5B5E);
    chk("raw_miss_hold", {31'b0, hold}, 32'd0);
    go;
    chk("raw_pend", {31'b0, empty}, 32'd0);
    ld(32'h102);
    @(negedge clk);
    chk("raw_hit_hold", {31'b0, hold}, 32'd1);
    chk("raw_hit_addr", mem_addr, 32'h100);
    chk("raw_hit_data", mem_wdata, 32'hDEADBEEF);
    go;
    @(negedge clk);
    chk("raw_srv_hold", {31'b0, hold}, 32'd0);
    chk("raw_srv_rd", ex_rdata, 32'h5A5A5B58);
    go; idle;
    wait_empty("raw_empty");
    mem_hold = 1;
    st(32'h300, 32'h3); go;
    st(32'h304, 32'h4); go;
    mem_hold = 0;
    ld(32'h200);
    @(negedge clk);
    chk("pri_we", {31'b0, mem_we}, 32'd0);
    chk("pri_addr", mem_addr, 32'h200);
    go; idle;
    @(negedge clk);
    chk("pri_res_we", {31'b0, mem_we}, 32'd1);
    chk("pri_res_addr", mem_addr, 32'h300);
    go;
    wait_empty("pri_empty");
    mem_hold = 1;
    st(32'h400, 1); go;
    st(32'h404, 2); go;
    st(32'h408, 3); go;
    idle; mem_hold = 0; drain_req = 1;
    go;
    st(32'h500, 5);
    @(negedge clk) chk("fl_hold1", {31'b0, hold}, 32'd1);
    go;
    @(negedge clk) chk("fl_hold2", {31'b0, hold}, 32'd1);
    go;
    drain_req = 0;
    @(negedge clk);
    chk("fl_empty", {31'b0, empty}, 32'd1);
    chk("fl_acc", {31'b0, hold}, 32'd0);
    go; idle;
    wait_empty("fl_done");
    mem_hold = 1;
    st(32'h600, 6); go;
    st(32'h604, 7); go;
    idle;
    wlog.delete();
    rst_n = 0;
    @(negedge clk);
    chk("rst_mid_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mid_empty", {31'b0, empty}, 32'd1);
    go;
    rst_n = 1; mem_hold = 0;
    repeat (4) go;
    @(negedge clk);
    chk("rst_mid_nowr", wlog.size(), 32'd0);
    chk("rst_mid_emp2", {31'b0, empty}, 32'd1);
    go;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
